// File: rtl/reg_bus_master.sv
// Byte-stream register bus master.
// Command frames arrive one byte at a time on rx: 'W' addr data performs a
// bus write and answers 8'hAA; 'R' addr waits READ_LAT cycles and answers
// with the low byte of bus_rdata. Unknown opcodes answer 8'hEE. A stalled
// frame (no byte for TIMEOUT cycles in ADDR/DATA) is dropped silently with
// an err pulse.
module reg_bus_master #(
  parameter int DATA_WIDTH = 8,
  parameter int READ_LAT   = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  err
);

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  // Timeout counter only needs to reach TIMEOUT-1: the expiring cycle is
  // detected combinationally rather than by storing TIMEOUT itself.
  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    RD_LAST = 4'(READ_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    READ_WAIT,
    RESP,
    ERR_RESP
  } state_t;

  state_t        state, state_n;
  logic          op_wr;
  logic [TW-1:0] to_cnt;
  logic [3:0]    rd_cnt;
  logic          accept;
  logic          to_hit;
  logic          op_ok;

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode and handshake/strobe outputs.
  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    bus_we   = 1'b0;
    tx_valid = 1'b0;
    to_hit   = 1'b0;
    busy     = (state != IDLE);
    op_ok    = (rx_data == OP_W) || (rx_data == OP_R);
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = op_ok ? ADDR : ERR_RESP;
      end
      ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          state_n = op_wr ? DATA : READ_WAIT;
        end else if (to_cnt == TO_LAST) begin
          to_hit  = 1'b1;
          state_n = IDLE;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          state_n = WRITE;
        end else if (to_cnt == TO_LAST) begin
          to_hit  = 1'b1;
          state_n = IDLE;
        end
      end
      WRITE: begin
        bus_we  = 1'b1;
        state_n = RESP;
      end
      READ_WAIT: begin
        if (rd_cnt == RD_LAST) state_n = RESP;
      end
      RESP, ERR_RESP: begin
        tx_valid = 1'b1;
        if (tx_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    accept = rx_ready && rx_valid;
  end

  // Datapath: opcode, bus address/data, response byte, counters, err pulse.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      op_wr     <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      tx_data   <= '0;
      err       <= 1'b0;
      to_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      err    <= 1'b0;
      to_cnt <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_wr <= (rx_data == OP_W);
            if (!op_ok) begin
              tx_data <= RSP_ERR;
              err     <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (accept)      bus_addr <= DATA_WIDTH'(rx_data);
          else if (to_hit) err      <= 1'b1;
          else             to_cnt   <= to_cnt + 1'b1;
        end
        DATA: begin
          if (accept)      bus_wdata <= DATA_WIDTH'(rx_data);
          else if (to_hit) err       <= 1'b1;
          else             to_cnt    <= to_cnt + 1'b1;
        end
        WRITE: tx_data <= RSP_OK;
        READ_WAIT: begin
          if (rd_cnt == RD_LAST) begin
            rd_cnt  <= '0;
            tx_data <= 8'(bus_rdata);
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: directed frames followed by
// random frames, checked against a frame-level reference model.
module tb_reg_bus_master;

  localparam int DW = 8;
  localparam int RL = 2;
  localparam int TO = 16;
  localparam logic [7:0] W = 8'h57;
  localparam logic [7:0] R = 8'h52;

  logic          clk = 1'b0;
  logic          res;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_we;
  logic [DW-1:0] bus_rdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  reg_bus_master #(.DATA_WIDTH(DW), .READ_LAT(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .res(res),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err)
  );

  // Peripheral: register file with registered read data.
  logic [7:0] pmem [256];
  always @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < 256; i++) pmem[i] <= 8'(i * 7 + 3);
      bus_rdata <= '0;
    end else begin
      if (bus_we) pmem[bus_addr] <= bus_wdata;
      bus_rdata <= pmem[bus_addr];
    end
  end

  // Observers, sampled on the falling edge.
  logic [15:0] wq [$];
  logic [7:0]  rq [$];
  int we_cycles = 0, tv_cycles = 0, err_cycles = 0, acc = 0;
  int rw_cycles = 0, stab_errs = 0;
  logic tv_prev = 1'b0, hs_prev = 1'b0;
  logic [7:0] td_prev = '0;
  always @(negedge clk) begin
    if (res) begin
      tv_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (bus_we) begin
        we_cycles++;
        wq.push_back({bus_addr, bus_wdata});
      end
      if (tx_valid) begin
        tv_cycles++;
        if (tv_prev && !hs_prev && tx_data !== td_prev) stab_errs++;
      end
      if (tx_valid && tx_ready) rq.push_back(tx_data);
      if (err) err_cycles++;
      if (rx_valid && rx_ready) acc++;
      if (busy && !rx_ready && !tx_valid && !bus_we) rw_cycles++;
      tv_prev = tx_valid;
      td_prev = tx_data;
      hs_prev = tx_valid && tx_ready;
    end
  end

  int tests = 0;
  int fails = 0;
  logic [7:0] mm [256];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mm[i] = 8'(i * 7 + 3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    rx_data  = b;
    rx_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_not_busy();
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("busy_drop", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // One frame: nsend bytes of {b0,b1,b2} with 'gap' idle cycles between
  // bytes, response held off for 'hold' cycles. Expected outcome derives
  // from the protocol rules only.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int nsend,
                           input int gap, input int hold);
    int w0 = wq.size();
    int r0 = rq.size();
    int e0 = err_cycles;
    int need;
    int n;
    bit ok;
    bit seen;
    bit exp_w = 1'b0;
    bit exp_resp = 1'b0;
    int exp_e = 0;
    logic [7:0] exp_rb = 8'h00;
    logic [7:0] bytes [3];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    if (b0 != W && b0 != R) need = 1;
    else if (b0 == W)       need = 3;
    else                    need = 2;
    if (need == 1) begin
      exp_resp = 1'b1;
      exp_rb   = 8'hEE;
      exp_e    = 1;
    end else if (nsend < need) begin
      exp_e = 1;
    end else if (b0 == W) begin
      exp_w    = 1'b1;
      exp_resp = 1'b1;
      exp_rb   = 8'hAA;
      mm[b1]   = b2;
    end else begin
      exp_resp = 1'b1;
      exp_rb   = mm[b1];
    end
    n = (nsend < need) ? nsend : need;
    tx_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i], ok);
      check("rx_accept", 32'(ok), 32'd1);
      if (i + 1 < n) idle(gap);
    end
    if (nsend < need) idle(TO + 2);
    if (exp_resp) begin
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (tx_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("resp_seen", 32'(seen), 32'd1);
      idle(hold + 1);
      tx_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (rq.size() > r0) break;
      end
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
    end
    wait_not_busy();
    check("write_count", 32'(wq.size() - w0), 32'(exp_w));
    if (exp_w && wq.size() > w0)
      check("write_addr_data", 32'(wq[w0]), 32'({b1, b2}));
    check("resp_count", 32'(rq.size() - r0), 32'(exp_resp));
    if (exp_resp && rq.size() > r0)
      check("resp_byte", 32'(rq[r0]), 32'(exp_rb));
    check("err_cycles", 32'(err_cycles - e0), 32'(exp_e));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(bus_addr),  32'd0);
    check({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
    check({tag, "_we"},    32'(bus_we),    32'd0);
    check({tag, "_txd"},   32'(tx_data),   32'd0);
    check({tag, "_txv"},   32'(tx_valid),  32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_rdy"},   32'(rx_ready),  32'd1);
  endtask

  initial begin
    int w0, r0, e0, t0, rw0, a0;
    bit ok;
    bit seen;
    logic [7:0] op, a, d;
    int kind, gap, hold, ns;

    res      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    res = 1'b0;
    idle(1);

    // Write with tx_ready already high: one bus_we cycle, one tx_valid cycle.
    tx_ready = 1'b1;
    w0 = wq.size(); r0 = rq.size(); t0 = tv_cycles;
    send_byte(W, ok);
    send_byte(8'h22, ok);
    send_byte(8'h05, ok);
    mm[8'h22] = 8'h05;
    wait_not_busy();
    tx_ready = 1'b0;
    check("wr_we_cycles", 32'(wq.size() - w0), 32'd1);
    if (wq.size() > w0) check("wr_entry", 32'(wq[w0]), 32'h2205);
    check("wr_txv_cycles", 32'(tv_cycles - t0), 32'd1);
    if (rq.size() > r0) check("wr_resp", 32'(rq[r0]), 32'hAA);
    else check("wr_resp_count", 32'(rq.size() - r0), 32'd1);

    // Read of a register holding 01, address held for READ_LAT cycles.
    run_frame(W, 8'h21, 8'h01, 3, 0, 0);
    rw0 = rw_cycles;
    run_frame(R, 8'h21, 8'h00, 2, 0, 0);
    check("rd_wait_cycles", 32'(rw_cycles - rw0), 32'(RL));
    check("rd_addr_kept", 32'(bus_addr), 32'h21);

    // Bad opcode then a normal write.
    run_frame(8'h41, 8'h00, 8'h00, 1, 0, 0);
    run_frame(W, 8'h20, 8'h01, 3, 2, 1);

    // Timeout in DATA, in ADDR, and a byte on the last allowed cycle.
    run_frame(W, 8'h22, 8'h00, 2, 0, 0);
    check("to_busy", 32'(busy), 32'd0);
    run_frame(R, 8'h10, 8'h00, 1, 0, 0);
    run_frame(W, 8'h30, 8'h44, 3, TO - 1, 0);
    run_frame(R, 8'h30, 8'h00, 2, TO - 1, 0);

    // Response held off 5 cycles with an rx byte pending.
    tx_ready = 1'b0;
    r0 = rq.size(); e0 = err_cycles;
    send_byte(R, ok);
    send_byte(8'h21, ok);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_resp_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    rx_data = 8'h41;
    rx_valid = 1'b1;
    a0 = acc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rx_ready", 32'(rx_ready), 32'd0);
      check("hold_tx_data", 32'(tx_data), 32'(mm[8'h21]));
      @(posedge clk);
      #1;
    end
    check("hold_not_consumed", 32'(acc - a0), 32'd0);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("pending_consumed", 32'(acc - a0), 32'd1);
    tx_ready = 1'b1;
    wait_not_busy();
    tx_ready = 1'b0;
    check("hold_resp_count", 32'(rq.size() - r0), 32'd2);
    if (rq.size() >= r0 + 2) begin
      check("hold_resp_first", 32'(rq[r0]), 32'(mm[8'h21]));
      check("hold_resp_second", 32'(rq[r0 + 1]), 32'hEE);
    end
    check("hold_err", 32'(err_cycles - e0), 32'd1);

    // Reset asserted just before the write cycle.
    tx_ready = 1'b1;
    w0 = we_cycles; r0 = rq.size();
    send_byte(W, ok);
    send_byte(8'h22, ok);
    rx_data = 8'h05;
    rx_valid = 1'b1;
    @(negedge clk);
    res = 1'b1;
    #1;
    check_reset_outputs("midres");
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    idle(2);
    check("midres_no_we", 32'(we_cycles - w0), 32'd0);
    check("midres_no_resp", 32'(rq.size() - r0), 32'd0);
    res = 1'b0;
    tx_ready = 1'b0;
    model_reset();
    idle(1);
    run_frame(W, 8'h22, 8'h05, 3, 1, 0);
    run_frame(R, 8'h22, 8'h00, 2, 1, 2);

    // Random frames.
    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 3));
      a    = 8'($urandom_range(0, 15));
      d    = 8'($urandom);
      gap  = int'($urandom_range(0, TO - 1));
      hold = int'($urandom_range(0, 3));
      case (kind)
        0: run_frame(W, a, d, 3, gap, hold);
        1: run_frame(R, a, d, 2, gap, hold);
        2: begin
          op = 8'($urandom);
          while (op == W || op == R) op = 8'($urandom);
          run_frame(op, a, d, 1, gap, hold);
        end
        default: begin
          op = ($urandom_range(0, 1) == 0) ? W : R;
          ns = (op == W) ? int'($urandom_range(1, 2)) : 1;
          run_frame(op, a, d, ns, gap, hold);
        end
      endcase
    end

    check("tx_data_stable", 32'(stab_errs), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the bus address and data ports.
REQ-002 Parameter READ_LAT, default 2, range 1..15, SHALL set the cycles between driving bus_addr for a read and sampling bus_rdata.
REQ-003 Parameter TIMEOUT, default 1000, SHALL set the maximum idle cycles allowed between bytes of one frame.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 res  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 rx_data  in  8  SHALL carry the incoming command byte.
REQ-007 rx_valid  in  1  SHALL indicate that rx_data is valid.
REQ-008 rx_ready  out  1  SHALL indicate that the block accepts a byte this cycle.
REQ-009 bus_addr  out  DATA_WIDTH  SHALL be the register address driven to peripherals.
REQ-010 bus_wdata  out  DATA_WIDTH  SHALL be the write data driven to peripherals.
REQ-011 bus_we  out  1  SHALL be the write strobe to peripherals.
REQ-012 bus_rdata  in  DATA_WIDTH  SHALL be the registered read data returned by peripherals.
REQ-013 tx_data  out  8  SHALL carry the response byte.
REQ-014 tx_valid  out  1  SHALL indicate that tx_data is valid.
REQ-015 tx_ready  in  1  SHALL indicate that the consumer accepts tx_data.
REQ-016 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-017 err  out  1  SHALL pulse high for one cycle on any protocol error.

Function
REQ-018 A byte SHALL be accepted only on a cycle where rx_valid and rx_ready are both high; rx_ready SHALL be high only in IDLE, ADDR and DATA.
REQ-019 The FSM SHALL use states IDLE, ADDR, DATA, WRITE, READ_WAIT, RESP and ERR_RESP.
REQ-020 In IDLE, opcode 8'h57 ('W') or 8'h52 ('R') SHALL be latched and the FSM SHALL move to ADDR; any other accepted byte SHALL move the FSM to ERR_RESP.
REQ-021 In ADDR, the accepted byte SHALL be latched into bus_addr (zero-extended or truncated to DATA_WIDTH); then 'W' -> DATA and 'R' -> READ_WAIT.
REQ-022 In DATA, the accepted byte SHALL be latched into bus_wdata and the FSM SHALL move to WRITE.
REQ-023 In WRITE, bus_we SHALL be high for exactly one cycle with bus_addr and bus_wdata stable; the FSM SHALL then load tx_data=8'hAA and move to RESP.
REQ-024 In READ_WAIT, bus_addr SHALL be held for READ_LAT cycles, counted by a 4-bit counter; on the last cycle bus_rdata[7:0] SHALL be captured into tx_data, zero-filled if DATA_WIDTH<8, and the FSM SHALL move to RESP.
REQ-025 In RESP and ERR_RESP, tx_valid SHALL be high and tx_data stable until tx_ready is sampled high; the FSM SHALL then move to IDLE on the following cycle.
REQ-026 Entry to ERR_RESP SHALL load tx_data=8'hEE and pulse err for one cycle.
REQ-027 bus_we SHALL be low in every state except WRITE, and bus_addr/bus_wdata SHALL keep their last values outside a frame.
REQ-028 In ADDR or DATA, a timeout counter SHALL count cycles with no accepted byte; on reaching TIMEOUT the FSM SHALL return to IDLE, pulse err, send no response and issue no bus write.
REQ-029 The timeout counter SHALL clear on every accepted byte and on entry to IDLE.
REQ-030 The byte accepted on the same cycle the counter reaches TIMEOUT SHALL win, the timeout SHALL be ignored, and the byte SHALL be processed.
REQ-031 rx_valid while tx_valid is pending SHALL NOT be accepted, because rx_ready is low; no byte SHALL be lost or duplicated.
REQ-032 Back-to-back frames SHALL be supported with one IDLE cycle between the response handshake and the next opcode.

Reset
REQ-033 While res is high, the FSM SHALL be IDLE and bus_addr, bus_wdata, bus_we, tx_data, tx_valid, err, busy and all counters SHALL be 0, with rx_ready=1.
REQ-034 res asserted mid-frame SHALL immediately abort the frame with no bus_we pulse and no response.

Verification
REQ-035 Feed 57,22,05 with tx_ready=1 -> bus_we high for one cycle with addr=22, wdata=05; then tx_data=AA with one tx_valid cycle.
REQ-036 Feed 52,21 with bus_rdata=01 and READ_LAT=2 -> addr=21 held for 2 cycles; then tx_data=01 and bus_we never high.
REQ-037 Feed 41 -> err pulses once and tx_data=EE; then 57,20,01 is processed normally.
REQ-038 Feed 57,22 and then idle for TIMEOUT cycles -> err pulses, busy drops, no bus_we and no tx_valid.
REQ-039 Read response held with tx_ready=0 for 5 cycles -> tx_data stable, rx_ready=0 and an offered rx byte not consumed; it is consumed after the handshake.
REQ-040 Assert res between DATA and WRITE -> bus_we stays 0, all outputs go 0, and the next frame works.
